pixel_array_ctrl: RTL and testbench
===================================

# pixel_array_ctrl

Frame sequencer for the 4-pixel sensor array. Drives the pixel control strobes through erase, expose, conversion and readout. During conversion it drives the shared 8-bit ADC counter onto all four DATA buses. During readout it captures the four pixel codes and streams them out one at a time over a valid/ready interface. It sits between the system controller, which issues `start`, and the pixel array and its bidirectional DATA buses.

## Interface
- `C_ERASE_CYCLES`, 5: cycles with erase/reset asserted (≥1)
- `C_EXPOSE_CYCLES`, 100: exposure length in cycles (≥1)
- `C_READ_CYCLES`, 2: READ assertion length; buses sampled on the last cycle (≥2)
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last pixel is accepted
- `pix_erase`  out  1  to array ERASE
- `pix_reset`  out  1  to array RESET
- `pix_expose`  out  1  to array EXPOSE
- `pix_ramp`  out  1  to array RAMP; high while the counter runs
- `pix_read`  out  1  to array READ
- `DATA1`..`DATA4`  inout  8  pixel buses; driven by this block only in CONVERT
- `pix_valid`  out  1  output pixel code valid
- `pix_ready`  in  1  downstream accepts
- `pix_data`  out  8  pixel code (binary)
- `pix_idx`  out  2  pixel number 0..3 for `pix_data`

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → TURN → READ → OUT → IDLE.
- IDLE: all strobes 0, buses Z. `start`=1 moves to ERASE on the next edge.
- ERASE: `pix_erase`=`pix_reset`=1 for `C_ERASE_CYCLES` cycles.
- EXPOSE: `pix_expose`=1 for `C_EXPOSE_CYCLES` cycles.
- CONVERT: `pix_ramp`=1 for 256 cycles.
  - 8-bit counter runs 0..255, incrementing every cycle.
  - The same value is driven on DATA1..DATA4.
  - The pixels latch the bus value when their comparator trips.
- TURN: one cycle with buses Z and all strobes 0, to prevent contention.
- READ: `pix_read`=1 for `C_READ_CYCLES` cycles, buses Z. On the last READ cycle, DATA1..4 are registered into capture regs 0..3.
- OUT: presents capture[k] with `pix_idx`=k, k=0..3.
  - Advance on `pix_valid && pix_ready`.
  - `pix_data`/`pix_idx` stay stable while stalled.
  - After k=3 is accepted: `done`=1 for one cycle, return to IDLE.
- `start` outside IDLE is ignored (not queued).
- Bus values are passed through unmodified. A pixel that never tripped reports whatever it holds; no saturation or check is applied.
- Only one state drives the buses (CONVERT). READ never overlaps driving.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `pix_erase`, `pix_reset`, `pix_expose`, `pix_ramp`, `pix_read`, `pix_valid` = 0
  - `pix_data`=0, `pix_idx`=0, counter 0, captures 0
  - DATA1..4 = Z
- All outputs are registered.
- `start` sampled high at edge N: `pix_erase`/`pix_reset`/`busy` high from N+1.
- With E=`C_ERASE_CYCLES`, X=`C_EXPOSE_CYCLES`, R=`C_READ_CYCLES`:
  - ERASE occupies E cycles.
  - EXPOSE occupies the next X cycles.
  - CONVERT occupies 256 cycles.
  - TURN occupies 1 cycle.
  - READ occupies R cycles.
  - `pix_valid` rises on the cycle after the last READ cycle.
- Frame length with `pix_ready` tied high is E+X+256+1+R+4 cycles, then one cycle of `done` in IDLE.
- `done` and `busy`=0 coincide in the first IDLE cycle.
- Counter wraps 255→0 only at the CONVERT exit and is cleared on entry. There is no mid-conversion wrap.
- `reset` mid-operation:
  - Immediately releases the buses.
  - Drops all strobes and `pix_valid`.
  - Returns to IDLE with no `done`.

## Configuration
- `PIXCTRL_GRAY_EN` defined:
  - The counter is Gray-coded on the buses: bus = c ^ (c>>1).
  - Captured values are Gray-decoded to binary before `pix_data`.
  - Timing is unchanged.
- Undefined: the counter is driven in plain binary and captures are passed directly.

## Test plan
- Defaults, `pix_ready`=1, buses weak-pulled and all pixels model a trip at count 0x40 (latching the bus value at that point):
  - `pix_data`=0x40 for idx 0..3.
  - `done` pulse 5+100+256+1+2+4 = 368 cycles after the first ERASE cycle.
- Pixels trip at 0x00, 0x7F, 0xFF, never:
  - Codes 0x00, 0x7F, 0xFF, then the held value, in idx order.
  - With `PIXCTRL_GRAY_EN`, DATA shows 0x40 (Gray of 0x7F) at count 0x7F and output remains 0x7F.
- Back-pressure: `pix_ready` low for 10 cycles at idx 1:
  - `pix_valid`=1, `pix_idx`=1 and data held stable.
  - idx 2 appears one cycle after ready rises.
- `start` pulsed during EXPOSE and during OUT:
  - No effect; exactly one `done` per frame.
- `reset` asserted at CONVERT count 0x20:
  - Buses Z and all outputs at reset values in the same cycle.
  - After release, a new `start` runs a full frame correctly.
- Bus contention check:
  - DATA is never driven by the controller while `pix_read`=1.
  - TURN cycle present between the last counter value and the READ rise.

Source files
------------

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 4-pixel sensor array: erase, expose, ramp conversion, readout and streaming.
// Optional build macro PIXCTRL_GRAY_EN selects a Gray-coded conversion counter on the DATA buses.
module pixel_array_ctrl #(
  parameter int C_ERASE_CYCLES  = 5,
  parameter int C_EXPOSE_CYCLES = 100,
  parameter int C_READ_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pix_erase,
  output logic       pix_reset,
  output logic       pix_expose,
  output logic       pix_ramp,
  output logic       pix_read,
  inout  wire  [7:0] DATA1,
  inout  wire  [7:0] DATA2,
  inout  wire  [7:0] DATA3,
  inout  wire  [7:0] DATA4,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [7:0] pix_data,
  output logic [1:0] pix_idx
);

  localparam int TMAX_EX = (C_EXPOSE_CYCLES > C_ERASE_CYCLES) ? C_EXPOSE_CYCLES : C_ERASE_CYCLES;
  localparam int TMAX    = (TMAX_EX > C_READ_CYCLES) ? TMAX_EX : C_READ_CYCLES;
  localparam int TMR_W   = $clog2(TMAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_TURN, S_READ, S_OUT
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [7:0]       cnt;
  logic             drv;
  logic [7:0]       cap [4];
  logic [7:0]       bus_val;

  function automatic logic [7:0] bus_code(input logic [7:0] c);
`ifdef PIXCTRL_GRAY_EN
    return c ^ (c >> 1);
`else
    return c;
`endif
  endfunction

  function automatic logic [7:0] pix_code(input logic [7:0] g);
`ifdef PIXCTRL_GRAY_EN
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
`else
    return g;
`endif
  endfunction

  // The buses are only ever driven from the registered enable, so reset releases them at once.
  assign bus_val = bus_code(cnt);
  assign DATA1 = drv ? bus_val : 8'hzz;
  assign DATA2 = drv ? bus_val : 8'hzz;
  assign DATA3 = drv ? bus_val : 8'hzz;
  assign DATA4 = drv ? bus_val : 8'hzz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      tmr        <= '0;
      cnt        <= '0;
      drv        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pix_erase  <= 1'b0;
      pix_reset  <= 1'b0;
      pix_expose <= 1'b0;
      pix_ramp   <= 1'b0;
      pix_read   <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_idx    <= '0;
      for (int i = 0; i < 4; i++) cap[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ERASE;
            busy      <= 1'b1;
            pix_erase <= 1'b1;
            pix_reset <= 1'b1;
            tmr       <= '0;
          end
        end
        S_ERASE: begin
          if (tmr == TMR_W'(C_ERASE_CYCLES - 1)) begin
            state      <= S_EXPOSE;
            pix_erase  <= 1'b0;
            pix_reset  <= 1'b0;
            pix_expose <= 1'b1;
            tmr        <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_EXPOSE: begin
          if (tmr == TMR_W'(C_EXPOSE_CYCLES - 1)) begin
            state      <= S_CONVERT;
            pix_expose <= 1'b0;
            pix_ramp   <= 1'b1;
            drv        <= 1'b1;
            cnt        <= '0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        // Counter runs a full 0..255 sweep; the wrap to 0 coincides with leaving the ramp.
        S_CONVERT: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hff) begin
            state    <= S_TURN;
            pix_ramp <= 1'b0;
            drv      <= 1'b0;
          end
        end
        S_TURN: begin
          state    <= S_READ;
          pix_read <= 1'b1;
          tmr      <= '0;
        end
        S_READ: begin
          if (tmr == TMR_W'(C_READ_CYCLES - 1)) begin
            cap[0]    <= pix_code(DATA1);
            cap[1]    <= pix_code(DATA2);
            cap[2]    <= pix_code(DATA3);
            cap[3]    <= pix_code(DATA4);
            state     <= S_OUT;
            pix_read  <= 1'b0;
            pix_valid <= 1'b1;
            pix_data  <= pix_code(DATA1);
            pix_idx   <= 2'd0;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        S_OUT: begin
          if (pix_valid && pix_ready) begin
            if (pix_idx == 2'd3) begin
              state     <= S_IDLE;
              pix_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              pix_idx  <= pix_idx + 2'd1;
              pix_data <= cap[pix_idx + 2'd1];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl: pixel model on the DATA buses, table-driven and random frames.
// Honours PIXCTRL_GRAY_EN for the expected bus encoding.
module tb_pixel_array_ctrl;
  localparam int E = 5, X = 100, R = 2;
  localparam int T_VALID = E + X + 256 + 1 + R;
  localparam int T_DONE  = T_VALID + 4;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, pix_ready = 1'b1;
  logic busy, done, pix_erase, pix_reset, pix_expose, pix_ramp, pix_read, pix_valid;
  logic [7:0] pix_data;
  logic [1:0] pix_idx;
  wire  [7:0] DATA1, DATA2, DATA3, DATA4;

  int checks = 0, failures = 0;
  int cyc_n = 0, ramp_i = 0, last_ramp = -100, done_cnt = 0, frames_done = 0;
  logic prev_read = 1'b0;
  logic [3:0][8:0] trip_cfg  = '1;
  logic [3:0][7:0] init_held = '0;
  logic [3:0][7:0] latched   = '0;
  logic [3:0]      tripped   = '0;

  typedef struct packed {
    logic [3:0][8:0] trip;
    logic [3:0][7:0] held;
    logic [3:0][7:0] exp;
    logic [2:0]      stall_idx;
    logic [7:0]      stall_len;
    logic            poke;
  } vec_t;
  vec_t vecs [3];

  pixel_array_ctrl #(.C_ERASE_CYCLES(E), .C_EXPOSE_CYCLES(X), .C_READ_CYCLES(R)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pix_erase(pix_erase), .pix_reset(pix_reset), .pix_expose(pix_expose),
    .pix_ramp(pix_ramp), .pix_read(pix_read),
    .DATA1(DATA1), .DATA2(DATA2), .DATA3(DATA3), .DATA4(DATA4),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_idx(pix_idx)
  );

  // Pixels drive their held code only while READ is asserted.
  assign DATA1 = pix_read ? (tripped[0] ? latched[0] : init_held[0]) : 8'hzz;
  assign DATA2 = pix_read ? (tripped[1] ? latched[1] : init_held[1]) : 8'hzz;
  assign DATA3 = pix_read ? (tripped[2] ? latched[2] : init_held[2]) : 8'hzz;
  assign DATA4 = pix_read ? (tripped[3] ? latched[3] : init_held[3]) : 8'hzz;

  always #5 clk = ~clk;

  function automatic int enc(input int c);
`ifdef PIXCTRL_GRAY_EN
    return (c ^ (c >> 1)) & 255;
`else
    return c & 255;
`endif
  endfunction

  function automatic int held_code(input int h);
`ifdef PIXCTRL_GRAY_EN
    int b = 0;
    for (int s = 0; s < 8; s++) b = b ^ (h >> s);
    return b & 255;
`else
    return h & 255;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // One cycle: advance to the falling edge, then run the pixel model and bus checks.
  task automatic tick();
    logic [3:0][7:0] b;
    @(negedge clk);
    cyc_n++;
    b = {DATA4, DATA3, DATA2, DATA1};
    if (pix_erase) tripped = '0;
    if (pix_ramp) begin
      chk("ramp_bus", (b[0] == b[1] && b[1] == b[2] && b[2] == b[3]) ? int'(b[0]) : -1, enc(ramp_i));
      for (int p = 0; p < 4; p++)
        if (int'(trip_cfg[p]) == ramp_i) begin
          latched[p] = b[p];
          tripped[p] = 1'b1;
        end
      ramp_i++;
      last_ramp = cyc_n;
    end else begin
      ramp_i = 0;
    end
    if (pix_read && !prev_read) chk("turn_gap", cyc_n - last_ramp, 2);
    if (pix_read) chk("contention", int'(dut.drv), 0);
    if (done) done_cnt++;
    prev_read = pix_read;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, int'({busy, done, pix_erase, pix_reset, pix_expose, pix_ramp, pix_read,
                    pix_valid, pix_data, pix_idx, dut.drv}), 0);
  endtask

  task automatic run_frame(input vec_t v);
    int t0, n, k;
    trip_cfg  = v.trip;
    init_held = v.held;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc_n;
    chk("start_strobes", int'({busy, pix_erase, pix_reset, pix_expose}), 4'b1110);
    n = 0;
    while (!pix_valid && n < 2000) begin
      start = (v.poke && pix_expose && n == 40);
      tick();
      n++;
    end
    start = 1'b0;
    if (!pix_valid) begin
      chk("valid_timeout", 0, 1);
      return;
    end
    chk("valid_latency", cyc_n - t0, T_VALID);
    for (k = 0; k < 4; k++) begin
      chk("out_idx", int'(pix_idx), k);
      chk("out_data", int'(pix_data), int'(v.exp[k]));
      chk("out_valid", int'(pix_valid), 1);
      if (k == int'(v.stall_idx)) begin
        pix_ready = 1'b0;
        for (int s = 0; s < int'(v.stall_len); s++) begin
          tick();
          chk("stall_hold", int'({pix_valid, pix_idx, pix_data}), int'({1'b1, 2'(k), v.exp[k]}));
        end
        pix_ready = 1'b1;
      end
      if (v.poke && k == 2) start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk("done_pulse", int'({done, busy, pix_valid}), 3'b100);
    if (v.stall_len == 0 || v.stall_idx > 3) chk("done_latency", cyc_n - t0, T_DONE);
    frames_done++;
    tick();
    chk("done_single", int'({done, busy}), 0);
  endtask

  function automatic vec_t model_vec(input logic [3:0][8:0] trip, input logic [3:0][7:0] held);
    vec_t v;
    v.trip = trip;
    v.held = held;
    for (int p = 0; p < 4; p++)
      v.exp[p] = (trip[p] < 9'd256) ? trip[p][7:0] : 8'(held_code(int'(held[p])));
    v.stall_idx = 3'd4;
    v.stall_len = 8'd0;
    v.poke = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t v;
    int n, dc;
    logic [3:0][8:0] tr;
    logic [3:0][7:0] hd;

    vecs[0].trip = {9'h040, 9'h040, 9'h040, 9'h040};
    vecs[0].held = {8'h11, 8'h22, 8'h33, 8'h44};
    vecs[0].exp  = {8'h40, 8'h40, 8'h40, 8'h40};
    vecs[0].stall_idx = 3'd4; vecs[0].stall_len = 8'd0; vecs[0].poke = 1'b0;
    vecs[1].trip = {9'h100, 9'h0ff, 9'h07f, 9'h000};
    vecs[1].held = {8'h5a, 8'h00, 8'h00, 8'h00};
`ifdef PIXCTRL_GRAY_EN
    vecs[1].exp  = {8'h6c, 8'hff, 8'h7f, 8'h00};
`else
    vecs[1].exp  = {8'h5a, 8'hff, 8'h7f, 8'h00};
`endif
    vecs[1].stall_idx = 3'd4; vecs[1].stall_len = 8'd0; vecs[1].poke = 1'b0;
    vecs[2].trip = {9'h0c3, 9'h081, 9'h020, 9'h010};
    vecs[2].held = {8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].exp  = {8'hc3, 8'h81, 8'h20, 8'h10};
    vecs[2].stall_idx = 3'd1; vecs[2].stall_len = 8'd10; vecs[2].poke = 1'b1;

    tick();
    chk_idle_outputs("reset_state");
    tick();
    reset = 1'b0;
    tick();
    chk_idle_outputs("idle_after_reset");

    for (int i = 0; i < 3; i++) run_frame(vecs[i]);
    chk("done_count_table", done_cnt, frames_done);

    trip_cfg  = {9'h050, 9'h050, 9'h050, 9'h050};
    init_held = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(pix_ramp && int'(DATA1) == enc(32)) && n < 1000) begin
      tick();
      n++;
    end
    chk("reach_count_20", int'(n < 1000), 1);
    dc = done_cnt;
    reset = 1'b1;
    #1;
    chk_idle_outputs("reset_midframe");
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("no_done_on_reset", done_cnt, dc);
    chk_idle_outputs("idle_after_abort");
    run_frame(vecs[0]);

    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < 4; p++) begin
        tr[p] = 9'($urandom_range(0, 256));
        hd[p] = 8'($urandom_range(0, 255));
      end
      v = model_vec(tr, hd);
      v.stall_idx = 3'($urandom_range(0, 4));
      v.stall_len = 8'($urandom_range(1, 6));
      run_frame(v);
    end
    chk("done_count_total", done_cnt, frames_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
